// File: rtl/butterfly2r_pipe_if.sv
// Handshake and data bundle for the radix-2 modular butterfly pipeline.
// master = upstream/downstream side, slave = the butterfly itself.
`timescale 1ns/1ps
interface butterfly2r_pipe_if #(
    parameter int W  = 16,
    parameter int SW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [W:0]    ai;
    logic [W:0]    bi;
    logic [SW-1:0] shift;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [W:0]    ao;
    logic [W:0]    bo;
    logic          err;

    modport master (
        output in_valid, ai, bi, shift, mode, out_ready,
        input  in_ready, out_valid, ao, bo, err
    );

    modport slave (
        input  in_valid, ai, bi, shift, mode, out_ready,
        output in_ready, out_valid, ao, bo, err
    );
endinterface

// File: rtl/butterfly2r_pipe.sv
// Three-stage radix-2 butterfly over the Fermat-style ring Z/(2^W+1),
// twiddles are powers of two realised as shift plus negate.
`timescale 1ns/1ps
module butterfly2r_pipe #(
    parameter int W  = 16,
    parameter int SW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    butterfly2r_pipe_if.slave  bus
);

    localparam logic [W+1:0] MOD   = {2'b01, {(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   TOP   = {1'b1, {W{1'b0}}};
    localparam logic [SW:0]  TWO_W = (SW+1)'(2*W);
    localparam logic [SW:0]  ONE_W = (SW+1)'(W);

    // Operands up to 2^(W+1)-1 are below 2*MOD, so one subtraction folds them.
    function automatic logic [W:0] fold_in(input logic [W:0] x);
        if (x > TOP)
            return x - MOD[W:0];
        return x;
    endfunction

    function automatic logic [W:0] madd(input logic [W:0] a, input logic [W:0] b);
        logic [W+1:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= MOD)
            s = s - MOD;
        return s[W:0];
    endfunction

    // a + MOD - b may wrap W+1 bits internally but the true result is < MOD.
    function automatic logic [W:0] msub(input logic [W:0] a, input logic [W:0] b);
        if (a >= b)
            return a - b;
        return a + MOD[W:0] - b;
    endfunction

    // x * 2^sh split into hi*2^W + lo, and 2^W == -1, so result = lo - hi.
    function automatic logic [W:0] twiddle(input logic [W:0]    x,
                                           input logic [SW-1:0] sh,
                                           input logic          neg);
        logic [2*W:0] p;
        logic [W:0]   r;
        p = {{W{1'b0}}, x} << sh;
        r = msub({1'b0, p[W-1:0]}, p[2*W:W]);
        if (neg)
            r = msub('0, r);
        return r;
    endfunction

    logic          en;
    logic          accept;

    logic          s_oor;
    logic [SW-1:0] s_red;
    logic          s_neg;
    logic [SW-1:0] s_sh;
    logic          op_oor;

    logic          v1;
    logic [W:0]    a1;
    logic [W:0]    b1;
    logic [SW-1:0] sh1;
    logic          neg1;
    logic          md1;

    logic          v2;
    logic [W:0]    p2;
    logic [W:0]    x2;
    logic [SW-1:0] sh2;
    logic          neg2;
    logic          md2;

    logic [W:0]    p2_d;
    logic [W:0]    x2_d;
    logic [W:0]    ao_d;
    logic [W:0]    bo_d;

    logic          v3;
    logic [W:0]    ao_q;
    logic [W:0]    bo_q;
    logic          err_q;

    assign en     = !v3 || bus.out_ready;
    assign accept = bus.in_valid && en;

    assign bus.in_ready  = en;
    assign bus.out_valid = v3;
    assign bus.ao        = ao_q;
    assign bus.bo        = bo_q;
    assign bus.err       = err_q;

    // Exponent decode: fold by the 2W period, then split into shift and sign.
    always_comb begin
        s_oor  = {1'b0, bus.shift} >= TWO_W;
        s_red  = s_oor ? bus.shift - TWO_W[SW-1:0] : bus.shift;
        s_neg  = {1'b0, s_red} >= ONE_W;
        s_sh   = s_neg ? s_red - ONE_W[SW-1:0] : s_red;
        op_oor = (bus.ai > TOP) || (bus.bi > TOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            sh1  <= '0;
            neg1 <= 1'b0;
            md1  <= 1'b0;
        end else if (en) begin
            v1   <= bus.in_valid;
            a1   <= fold_in(bus.ai);
            b1   <= fold_in(bus.bi);
            sh1  <= s_sh;
            neg1 <= s_neg;
            md1  <= bus.mode;
        end
    end

    // DIF forms sum/difference first; DIT applies the twiddle to b first.
    always_comb begin
        p2_d = a1;
        x2_d = twiddle(b1, sh1, neg1);
        if (!md1) begin
            p2_d = madd(a1, b1);
            x2_d = msub(a1, b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            p2   <= '0;
            x2   <= '0;
            sh2  <= '0;
            neg2 <= 1'b0;
            md2  <= 1'b0;
        end else if (en) begin
            v2   <= v1;
            p2   <= p2_d;
            x2   <= x2_d;
            sh2  <= sh1;
            neg2 <= neg1;
            md2  <= md1;
        end
    end

    always_comb begin
        ao_d = p2;
        bo_d = twiddle(x2, sh2, neg2);
        if (md2) begin
            ao_d = madd(p2, x2);
            bo_d = msub(p2, x2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3   <= 1'b0;
            ao_q <= '0;
            bo_q <= '0;
        end else if (en) begin
            v3   <= v2;
            ao_q <= ao_d;
            bo_q <= bo_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (accept && (op_oor || s_oor))
            err_q <= 1'b1;
    end

endmodule

// File: tb/tb_butterfly2r_pipe.sv
// Randomised and directed bench for butterfly2r_pipe against an arithmetic
// reference model in Z/65537 (SW widened to 6 so exponents past 2W are legal).
`timescale 1ns/1ps
module tb_butterfly2r_pipe;
    localparam int     W  = 16;
    localparam int     SW = 6;
    localparam longint M  = 65537;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    butterfly2r_pipe_if #(.W(W), .SW(SW)) bif();
    butterfly2r_pipe #(.W(W), .SW(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    int checks = 0;
    int errors = 0;

    typedef struct { longint ai; longint bi; int s; bit md; } set_t;
    typedef struct { longint ao; longint bo; } res_t;
    set_t acc_q[$];
    res_t out_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bif.in_valid && bif.in_ready) begin
                set_t t;
                t.ai = longint'(bif.ai);
                t.bi = longint'(bif.bi);
                t.s  = int'(bif.shift);
                t.md = bif.mode;
                acc_q.push_back(t);
            end
            if (bif.out_valid && bif.out_ready) begin
                res_t r;
                r.ao = longint'(bif.ao);
                r.bo = longint'(bif.bo);
                out_q.push_back(r);
            end
        end
    end

    function automatic void ref_bfly(input set_t st, output longint ao_e, output longint bo_e);
        longint a, b, tw, t;
        a  = st.ai % M;
        b  = st.bi % M;
        tw = 1;
        for (int i = 0; i < (st.s % (2*W)); i++) tw = (tw * 2) % M;
        if (!st.md) begin
            ao_e = (a + b) % M;
            bo_e = (((a - b + M) % M) * tw) % M;
        end else begin
            t    = (b * tw) % M;
            ao_e = (a + t) % M;
            bo_e = (a - t + M) % M;
        end
    endfunction

    task automatic idle_in();
        bif.in_valid = 1'b0;
        bif.ai       = '0;
        bif.bi       = '0;
        bif.shift    = '0;
        bif.mode     = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_in();
        bif.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc_q.delete();
        out_q.delete();
        @(posedge clk); #1;
    endtask

    // Returns at posedge+1 just after the accepting edge; in_valid stays high.
    task automatic send(input longint a, input longint b, input int s, input bit md);
        bit got = 1'b0;
        bif.in_valid = 1'b1;
        bif.ai       = a[W:0];
        bif.bi       = b[W:0];
        bif.shift    = s[SW-1:0];
        bif.mode     = md;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bif.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready stayed 0 for 50 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_out(output int lat, output longint ao, output longint bo);
        lat = 1;
        while (!bif.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        ao = longint'(bif.ao);
        bo = longint'(bif.bo);
    endtask

    task automatic test_reset();
        idle_in();
        bif.out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", bif.out_valid); end
        checks++; if (bif.err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b want 0", bif.err); end
        checks++; if (bif.ao !== '0) begin errors++; $display("FAIL rst_ao got %0d want 0", bif.ao); end
        checks++; if (bif.bo !== '0) begin errors++; $display("FAIL rst_bo got %0d want 0", bif.bo); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", bif.in_ready); end
        bif.out_ready = 1'b1;
    endtask

    task automatic test_directed();
        longint tai[8] = '{5, 3, 65536, 1, 1,     10, 65536, 0};
        longint tbi[8] = '{3, 5, 1,     0, 0,     1,  65536, 3};
        int     ts [8] = '{4, 0, 0,     16, 31,   4,  0,     17};
        bit     tm [8] = '{0, 0, 0,     0, 0,     1,  1,     1};
        longint eao[8] = '{8, 8, 0,     1, 1,     26, 65535, 65531};
        longint ebo[8] = '{32, 65535, 65535, 65536, 32769, 65531, 0, 6};
        int     lat;
        longint ao, bo;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(tai[i], tbi[i], ts[i], tm[i]);
            idle_in();
            wait_out(lat, ao, bo);
            checks++; if (lat != 3) begin errors++; $display("FAIL dir%0d_latency got %0d want 3", i, lat); end
            checks++; if (ao !== eao[i]) begin errors++; $display("FAIL dir%0d_ao got %0d want %0d", i, ao, eao[i]); end
            checks++; if (bo !== ebo[i]) begin errors++; $display("FAIL dir%0d_bo got %0d want %0d", i, bo, ebo[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int     sent = 0;
        int     cyc  = 0;
        longint ea, eb;
        acc_q.delete();
        out_q.delete();
        while (sent < 250 && cyc < 5000) begin
            bif.in_valid  = ($urandom_range(3) != 0);
            bif.ai        = ($urandom_range(7) == 0) ? 17'd65536 : 17'($urandom_range(65536));
            bif.bi        = 17'($urandom_range(65536));
            bif.shift     = 6'($urandom_range(31));
            bif.mode      = 1'($urandom_range(1));
            bif.out_ready = ($urandom_range(9) < 7);
            @(negedge clk);
            if (bif.in_valid && bif.in_ready) sent++;
            cyc++;
            @(posedge clk); #1;
        end
        idle_in();
        bif.out_ready = 1'b1;
        for (int n = 0; n < 40 && out_q.size() < acc_q.size(); n++) begin
            @(posedge clk); #1;
        end
        checks++; if (sent != 250) begin errors++; $display("FAIL rnd_sent got %0d want 250", sent); end
        checks++; if (out_q.size() != acc_q.size()) begin errors++; $display("FAIL rnd_count got %0d want %0d", out_q.size(), acc_q.size()); end
        for (int i = 0; i < out_q.size() && i < acc_q.size(); i++) begin
            ref_bfly(acc_q[i], ea, eb);
            checks++;
            if (out_q[i].ao !== ea || out_q[i].bo !== eb) begin
                errors++;
                $display("FAIL rnd%0d got ao=%0d bo=%0d want ao=%0d bo=%0d", i, out_q[i].ao, out_q[i].bo, ea, eb);
            end
        end
        checks++; if (bif.err !== 1'b0) begin errors++; $display("FAIL rnd_err got %0b want 0", bif.err); end
    endtask

    task automatic test_back_to_back();
        set_t   sets[6];
        int     idx = 0;
        logic [W:0] hold_ao, hold_bo;
        longint ea, eb;
        for (int i = 0; i < 6; i++) begin
            sets[i].ai = longint'($urandom_range(65536));
            sets[i].bi = longint'($urandom_range(65536));
            sets[i].s  = int'($urandom_range(31));
            sets[i].md = 1'($urandom_range(1));
        end
        out_q.delete();
        acc_q.delete();
        hold_ao = '0;
        hold_bo = '0;
        for (int k = 0; k < 20; k++) begin
            if (idx < 6) begin
                bif.in_valid = 1'b1;
                bif.ai       = sets[idx].ai[W:0];
                bif.bi       = sets[idx].bi[W:0];
                bif.shift    = SW'(sets[idx].s);
                bif.mode     = sets[idx].md;
            end else begin
                idle_in();
            end
            bif.out_ready = !(k >= 3 && k < 7);
            @(negedge clk);
            if (k >= 3 && k < 7) begin
                checks++; if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready k=%0d got %0b want 0", k, bif.in_ready); end
                checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid k=%0d got %0b want 1", k, bif.out_valid); end
                if (k == 3) begin
                    hold_ao = bif.ao;
                    hold_bo = bif.bo;
                end else begin
                    checks++; if (bif.ao !== hold_ao) begin errors++; $display("FAIL bp_hold_ao k=%0d got %0d want %0d", k, bif.ao, hold_ao); end
                    checks++; if (bif.bo !== hold_bo) begin errors++; $display("FAIL bp_hold_bo k=%0d got %0d want %0d", k, bif.bo, hold_bo); end
                end
            end
            if (bif.in_valid && bif.in_ready) idx++;
            @(posedge clk); #1;
        end
        bif.out_ready = 1'b1;
        checks++; if (out_q.size() != 6) begin errors++; $display("FAIL bp_count got %0d want 6", out_q.size()); end
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            ref_bfly(sets[i], ea, eb);
            checks++;
            if (out_q[i].ao !== ea || out_q[i].bo !== eb) begin
                errors++;
                $display("FAIL bp%0d got ao=%0d bo=%0d want ao=%0d bo=%0d", i, out_q[i].ao, out_q[i].bo, ea, eb);
            end
        end
    endtask

    task automatic test_errors();
        longint tai[6] = '{65537, 4,      9,     7,  7,  7};
        longint tbi[6] = '{2,     131071, 9,     3,  3,  3};
        int     ts [6] = '{3,     0,      5,     0,  32, 63};
        bit     tm [6] = '{0,     0,      1,     1,  1,  0};
        longint eao[6] = '{2,     1,      297,   10, 10, 10};
        longint ebo[6] = '{65521, 7,      65258, 4,  4,  2};
        bit     eer[6] = '{1,     1,      1,     0,  1,  1};
        int     lat;
        longint ao, bo;
        do_reset();
        checks++; if (bif.err !== 1'b0) begin errors++; $display("FAIL err_initial got %0b want 0", bif.err); end
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                do_reset();
                checks++; if (bif.err !== 1'b0) begin errors++; $display("FAIL err_cleared got %0b want 0", bif.err); end
            end
            send(tai[i], tbi[i], ts[i], tm[i]);
            idle_in();
            wait_out(lat, ao, bo);
            checks++; if (ao !== eao[i]) begin errors++; $display("FAIL err%0d_ao got %0d want %0d", i, ao, eao[i]); end
            checks++; if (bo !== ebo[i]) begin errors++; $display("FAIL err%0d_bo got %0d want %0d", i, bo, ebo[i]); end
            checks++; if (bif.err !== eer[i]) begin errors++; $display("FAIL err%0d_flag got %0b want %0b", i, bif.err, eer[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midstream();
        int     stale = 0;
        int     lat;
        longint ao, bo;
        do_reset();
        send(65537, 1, 0, 0);
        send(20, 5, 2, 1);
        send(300, 7, 9, 0);
        idle_in();
        checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %0b want 1", bif.out_valid); end
        checks++; if (bif.err !== 1'b1) begin errors++; $display("FAIL mid_pre_err got %0b want 1", bif.err); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %0b want 0", bif.out_valid); end
        checks++; if (bif.err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %0b want 0", bif.err); end
        checks++; if (bif.ao !== '0 || bif.bo !== '0) begin errors++; $display("FAIL mid_rst_data got ao=%0d bo=%0d want 0", bif.ao, bif.bo); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc_q.delete();
        out_q.delete();
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (bif.out_valid) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale got %0d want 0", stale); end
        checks++; if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %0b want 1", bif.in_ready); end
        send(100, 50, 1, 0);
        idle_in();
        wait_out(lat, ao, bo);
        checks++; if (lat != 3) begin errors++; $display("FAIL mid_latency got %0d want 3", lat); end
        checks++; if (ao !== 150 || bo !== 100) begin errors++; $display("FAIL mid_result got ao=%0d bo=%0d want ao=150 bo=100", ao, bo); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_errors();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/butterfly2r_pipe.md
BUTTERFLY2R_PIPE -- requirements
Module: butterfly2r_pipe

Interface
REQ-001 SHALL have parameter W, default 16: residue width; modulus M = 2^W + 1.
REQ-002 SHALL have parameter SW, default 5: shift-select width, sized to hold 0..2W-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input operand set valid.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port ai  input  W+1  operand A, unsigned residue 0..2^W.
REQ-008 SHALL have port bi  input  W+1  operand B, unsigned residue 0..2^W.
REQ-009 SHALL have port shift  input  SW  twiddle exponent S; twiddle = 2^S mod M.
REQ-010 SHALL have port mode  input  1  0 = DIF, 1 = DIT.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port ao  output  W+1  result A, canonical residue 0..M-1.
REQ-014 SHALL have port bo  output  W+1  result B, canonical residue 0..M-1.
REQ-015 SHALL have port err  output  1  sticky range-error flag.

Function
REQ-016 SHALL compute, DIF (mode=0): ao = (ai + bi) mod M; bo = ((ai - bi) * 2^S) mod M.
REQ-017 SHALL compute, DIT (mode=1): t = (bi * 2^S) mod M; ao = (ai + t) mod M; bo = (ai - t) mod M.
REQ-018 SHALL implement 2^S by shift/negate only, no multiplier: S < W -> x<<S reduced; W <= S < 2W -> negate of x<<(S-W) reduced (2^W = -1 mod M).
REQ-019 SHALL reduce differences to canonical form: a negative intermediate gains M; no output ever equals or exceeds M.
REQ-020 SHALL treat S >= 2W as S - 2W (2^(2W) = 1 mod M) and set err.
REQ-021 SHALL set err when an accepted ai or bi exceeds 2^W; that operand is used as its value mod M; err holds until reset.
REQ-022 SHALL be a 3-stage pipeline: a set accepted in cycle n appears on ao/bo with out_valid in cycle n+3 when no stall.
REQ-023 SHALL accept a transfer when in_valid and in_ready are both high; shift and mode are sampled with the operands.
REQ-024 SHALL advance all stages together when enable = !out_valid || out_ready; in_ready = enable.
REQ-025 SHALL, while out_valid high and out_ready low, hold ao, bo, out_valid and all internal stages stable.
REQ-026 SHALL propagate bubbles: a stage with no valid data carries valid=0; sustained throughput one set per cycle.
REQ-027 SHALL not drop or duplicate sets; output order equals acceptance order.
REQ-028 SHALL allow ao/bo arbitrary when out_valid is low.

Reset
REQ-029 SHALL, on rst_n low, immediately clear all stage valid bits, out_valid, ao, bo and err to 0, independent of clk.
REQ-030 SHALL discard all in-flight sets on reset; after rst_n rises, in_ready = 1 and first output follows 3 cycles after first acceptance.

Verification (W=16, M=65537)
REQ-031 SHALL cover DIF ai=5, bi=3, S=4, out_ready=1 -> 3 cycles later ao=8, bo=32, out_valid=1.
REQ-032 SHALL cover DIF wrap: ai=3, bi=5, S=0 -> ao=8, bo=65535; ai=65536, bi=1, S=0 -> ao=0, bo=65535.
REQ-033 SHALL cover negate twiddles: DIF ai=1, bi=0, S=16 -> bo=65536; S=31 -> bo=32769; DIT ai=10, bi=1, S=4 -> ao=26, bo=65531.
REQ-034 SHALL cover backpressure: stream 6 sets back-to-back, out_ready low 4 cycles mid-stream -> outputs held stable, in_ready low during stall, all 6 results in order, none lost.
REQ-035 SHALL cover errors: ai=65537 or S=32 -> err=1 and stays 1; S=32 result equals S=0 result.
REQ-036 SHALL cover reset mid-stream: rst_n low with 3 sets in flight -> out_valid and err 0 at once, no stale outputs after release.
